bcd_counter_display: RTL and testbench

Parametrised N-digit BCD up/down counter with synchronous clear, parallel load, wrap or saturate mode and an integrated multiplexed seven-segment driver. It is the general counter/display block for the board top level and replaces fixed 4-digit, up-only counters. The count runs on tick enables, and the display scan runs from an internal prescaler, all in one clock domain.

---
 rtl/bcd_counter_display_pkg.sv | 51 +++++
 rtl/bcd_counter_display_if.sv | 30 +++
 rtl/bcd_counter_display_scan.sv | 62 ++++++
 rtl/bcd_counter_display.sv | 100 ++++++++++
 tb/tb_bcd_counter_display.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/bcd_counter_display_pkg.sv
// Shared BCD constants, seven-segment patterns and the count-operation type
// used by the counter/display block.
package bcd_display_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t ZERO = 4'd0;
  localparam bcd_t NINE = 4'd9;

  // Active-low patterns, [7]=dp (always off), [6]=g ... [0]=a
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } count_op_t;

  function automatic logic [7:0] digit_to_seg(input bcd_t d);
    logic [7:0] seg;
    case (d)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bcd_counter_display_if.sv
// Request/status bundle of the BCD counter/display block; the board logic
// drives it through the master modport, the counter sits on the slave side.
interface bcd_counter_display_if
  import bcd_display_pkg::*;
#(
  parameter int unsigned DIGITS = 4
);

  logic                      countEnable;
  logic                      up;
  logic                      load;
  logic [BCD_W*DIGITS-1:0]   loadValue;
  logic                      clear;
  logic [BCD_W*DIGITS-1:0]   digitsOut;
  logic                      carryOut;
  logic                      borrowOut;
  logic [DIGITS-1:0]         controlOut;
  logic [7:0]                segOut;

  modport master (
    output countEnable, up, load, loadValue, clear,
    input  digitsOut, carryOut, borrowOut, controlOut, segOut
  );

  modport slave (
    input  countEnable, up, load, loadValue, clear,
    output digitsOut, carryOut, borrowOut, controlOut, segOut
  );

endinterface

// File: rtl/bcd_counter_display_scan.sv
// Multiplexed seven-segment scan: prescaler, digit index, digit mux and the
// registered controlOut/segOut drive.
module seven_seg_scan
  import bcd_display_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [BCD_W*DIGITS-1:0] value,
  output logic [DIGITS-1:0]       controlOut,
  output logic [7:0]              segOut
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]  pre, preNext;
  logic [IDX_W-1:0]  idx, idxNext;
  bcd_t              digitSel;
  logic [DIGITS-1:0] ctlNext;

  always_comb begin
    preNext = pre + 1'b1;
    idxNext = idx;
    if (pre == PRE_LAST) begin
      preNext = '0;
      idxNext = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // Outputs are registered from the next index so controlOut stays in phase
  // with the index register itself.
  always_comb begin
    digitSel = ZERO;
    ctlNext  = '1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idxNext == IDX_W'(k)) begin
        digitSel   = value[BCD_W*k +: BCD_W];
        ctlNext[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre        <= '0;
      idx        <= '0;
      controlOut <= ~DIGITS'(1);
      segOut     <= SEG_0;
    end else begin
      pre        <= preNext;
      idx        <= idxNext;
      controlOut <= ctlNext;
      segOut     <= digit_to_seg(digitSel);
    end
  end

endmodule

// File: rtl/bcd_counter_display.sv
// N-digit BCD up/down counter with clear, clamped parallel load, wrap or
// saturate mode, carry/borrow pulses and an integrated display scan.
module bcd_counter_display
  import bcd_display_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned WRAP     = 1
) (
  input  logic           clock,
  input  logic           reset,
  bcd_counter_display_if.slave bus
);

  logic [BCD_W*DIGITS-1:0] value, valueNext, incVal, decVal, loadClamped;
  logic                    allNines, allZeros;
  logic                    carry, borrow, carryNext, borrowNext;
  count_op_t               op;

  always_comb begin
    if (bus.clear)            op = OP_CLEAR;
    else if (bus.load)        op = OP_LOAD;
    else if (bus.countEnable) op = bus.up ? OP_UP : OP_DOWN;
    else                      op = OP_HOLD;
  end

  // Ripple flags run low-to-high digit; after the loop they report all-nines
  // and all-zeros of the whole value.
  always_comb begin
    logic rippleUp;
    logic rippleDn;
    bcd_t d;
    bcd_t n;
    incVal      = value;
    decVal      = value;
    loadClamped = '0;
    rippleUp    = 1'b1;
    rippleDn    = 1'b1;
    d           = ZERO;
    n           = ZERO;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      d = value[BCD_W*k +: BCD_W];
      n = bus.loadValue[BCD_W*k +: BCD_W];
      if (rippleUp) incVal[BCD_W*k +: BCD_W] = (d == NINE) ? ZERO : d + 4'd1;
      if (rippleDn) decVal[BCD_W*k +: BCD_W] = (d == ZERO) ? NINE : d - 4'd1;
      loadClamped[BCD_W*k +: BCD_W] = (n > NINE) ? NINE : n;
      rippleUp = rippleUp & (d == NINE);
      rippleDn = rippleDn & (d == ZERO);
    end
    allNines = rippleUp;
    allZeros = rippleDn;
  end

  always_comb begin
    valueNext  = value;
    carryNext  = 1'b0;
    borrowNext = 1'b0;
    case (op)
      OP_CLEAR: valueNext = '0;
      OP_LOAD:  valueNext = loadClamped;
      OP_UP: begin
        carryNext = allNines;
        if (!allNines || (WRAP != 0)) valueNext = incVal;
      end
      OP_DOWN: begin
        borrowNext = allZeros;
        if (!allZeros || (WRAP != 0)) valueNext = decVal;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value  <= '0;
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      value  <= valueNext;
      carry  <= carryNext;
      borrow <= borrowNext;
    end
  end

  assign bus.digitsOut = value;
  assign bus.carryOut  = carry;
  assign bus.borrowOut = borrow;

  seven_seg_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clock      (clock),
    .reset      (reset),
    .value      (value),
    .controlOut (bus.controlOut),
    .segOut     (bus.segOut)
  );

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed bench: 4-digit wrap and saturate counters plus a 1-digit counter,
// all with a 4-cycle scan slot, checked with immediate assertions.
module tb_bcd_counter_display;

  logic clock = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;

  bcd_counter_display_if #(.DIGITS(4)) ifw ();
  bcd_counter_display_if #(.DIGITS(4)) ifs ();
  bcd_counter_display_if #(.DIGITS(1)) ifo ();

  bcd_counter_display #(.DIGITS(4), .SCAN_DIV(4), .WRAP(1)) dut_wrap (
    .clock (clock), .reset (reset), .bus (ifw.slave)
  );
  bcd_counter_display #(.DIGITS(4), .SCAN_DIV(4), .WRAP(0)) dut_sat (
    .clock (clock), .reset (reset), .bus (ifs.slave)
  );
  bcd_counter_display #(.DIGITS(1), .SCAN_DIV(4), .WRAP(1)) dut_one (
    .clock (clock), .reset (reset), .bus (ifo.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_all();
    ifw.countEnable = 1'b0; ifw.up = 1'b0; ifw.load = 1'b0; ifw.clear = 1'b0;
    ifs.countEnable = 1'b0; ifs.up = 1'b0; ifs.load = 1'b0; ifs.clear = 1'b0;
    ifo.countEnable = 1'b0; ifo.up = 1'b0; ifo.load = 1'b0; ifo.clear = 1'b0;
  endtask

  logic [3:0] ctlExp [4];
  logic [7:0] segExp [4];
  logic [3:0] prevCtl;
  bit         found;

  initial begin
    ctlExp = '{4'hE, 4'hD, 4'hB, 4'h7};
    segExp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
    reset = 1'b1;
    idle_all();
    ifw.loadValue = '0; ifs.loadValue = '0; ifo.loadValue = '0;
    repeat (3) @(negedge clock);

    check("rst_w_digits", ifw.digitsOut, 32'h0);
    check("rst_w_carry", ifw.carryOut, 32'h0);
    check("rst_w_borrow", ifw.borrowOut, 32'h0);
    check("rst_w_ctl", ifw.controlOut, 32'hE);
    check("rst_w_seg", ifw.segOut, 32'hC0);
    check("rst_s_digits", ifs.digitsOut, 32'h0);
    check("rst_o_ctl", ifo.controlOut, 32'h0);
    check("rst_o_seg", ifo.segOut, 32'hC0);

    reset = 1'b0;
    @(negedge clock);
    check("post_rst_digits", ifw.digitsOut, 32'h0);
    check("post_rst_ctl", ifw.controlOut, 32'hE);

    // Ripple up, wrap mode
    ifw.load = 1'b1; ifw.loadValue = 16'h0998;
    @(negedge clock); ifw.load = 1'b0;
    check("load_0998", ifw.digitsOut, 32'h0998);
    ifw.countEnable = 1'b1; ifw.up = 1'b1;
    @(negedge clock);
    check("up_0999", ifw.digitsOut, 32'h0999);
    check("up_0999_carry", ifw.carryOut, 32'h0);
    @(negedge clock); ifw.countEnable = 1'b0;
    check("up_1000", ifw.digitsOut, 32'h1000);
    check("up_1000_carry", ifw.carryOut, 32'h0);
    ifw.load = 1'b1; ifw.loadValue = 16'h9999;
    @(negedge clock); ifw.load = 1'b0;
    check("load_9999_carry", ifw.carryOut, 32'h0);
    ifw.countEnable = 1'b1; ifw.up = 1'b1;
    @(negedge clock); ifw.countEnable = 1'b0;
    check("wrap_up_value", ifw.digitsOut, 32'h0000);
    check("wrap_up_carry", ifw.carryOut, 32'h1);
    @(negedge clock);
    check("wrap_up_carry_end", ifw.carryOut, 32'h0);
    ifw.countEnable = 1'b1; ifw.up = 1'b0;
    @(negedge clock); ifw.countEnable = 1'b0;
    check("wrap_dn_value", ifw.digitsOut, 32'h9999);
    check("wrap_dn_borrow", ifw.borrowOut, 32'h1);
    @(negedge clock);
    check("wrap_dn_borrow_end", ifw.borrowOut, 32'h0);

    // Saturate mode
    ifs.countEnable = 1'b1; ifs.up = 1'b0;
    @(negedge clock); ifs.countEnable = 1'b0;
    check("sat_dn_value", ifs.digitsOut, 32'h0000);
    check("sat_dn_borrow", ifs.borrowOut, 32'h1);
    @(negedge clock);
    check("sat_dn_borrow_end", ifs.borrowOut, 32'h0);
    ifs.load = 1'b1; ifs.loadValue = 16'h9999;
    @(negedge clock); ifs.load = 1'b0;
    ifs.countEnable = 1'b1; ifs.up = 1'b1;
    @(negedge clock); ifs.countEnable = 1'b0;
    check("sat_up_value", ifs.digitsOut, 32'h9999);
    check("sat_up_carry", ifs.carryOut, 32'h1);
    @(negedge clock);
    check("sat_up_carry_end", ifs.carryOut, 32'h0);
    ifs.countEnable = 1'b1; ifs.up = 1'b0;
    @(negedge clock); ifs.countEnable = 1'b0;
    check("sat_dn_9998", ifs.digitsOut, 32'h9998);

    // Priority and clamp (wrap DUT currently holds 9999)
    ifw.clear = 1'b1; ifw.load = 1'b1; ifw.loadValue = 16'h1234;
    ifw.countEnable = 1'b1; ifw.up = 1'b1;
    @(negedge clock); idle_all();
    check("prio_clear", ifw.digitsOut, 32'h0000);
    check("prio_clear_carry", ifw.carryOut, 32'h0);
    ifw.load = 1'b1; ifw.loadValue = 16'hAF37;
    @(negedge clock); ifw.load = 1'b0;
    check("load_clamp", ifw.digitsOut, 32'h9937);
    ifw.load = 1'b1; ifw.loadValue = 16'h0100; ifw.countEnable = 1'b1; ifw.up = 1'b1;
    @(negedge clock);
    check("prio_load", ifw.digitsOut, 32'h0100);
    ifw.loadValue = 16'h9999;
    @(negedge clock);
    check("prio_load_9999", ifw.digitsOut, 32'h9999);
    check("prio_load_carry", ifw.carryOut, 32'h0);
    idle_all();

    // Scan of 1234
    ifw.load = 1'b1; ifw.loadValue = 16'h1234;
    @(negedge clock); ifw.load = 1'b0;
    found   = 1'b0;
    prevCtl = ifw.controlOut;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clock);
      if (prevCtl != 4'hE && ifw.controlOut == 4'hE) found = 1'b1;
      prevCtl = ifw.controlOut;
    end
    check("scan_sync", {31'b0, found}, 32'h1);
    if (found) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 4; c++) begin
          check("scan_ctl", ifw.controlOut, {28'b0, ctlExp[s]});
          check("scan_seg", ifw.segOut, {24'b0, segExp[s]});
          @(negedge clock);
        end
      end
      check("scan_repeat_ctl", ifw.controlOut, 32'hE);
      check("scan_repeat_seg", ifw.segOut, 32'h99);
      repeat (4) @(negedge clock);
      check("scan_repeat_ctl1", ifw.controlOut, 32'hD);
    end

    // Single-digit counter
    ifo.load = 1'b1; ifo.loadValue = 4'hC;
    @(negedge clock); ifo.load = 1'b0;
    check("one_clamp", ifo.digitsOut, 32'h9);
    ifo.countEnable = 1'b1; ifo.up = 1'b1;
    @(negedge clock); ifo.countEnable = 1'b0;
    check("one_wrap_value", ifo.digitsOut, 32'h0);
    check("one_wrap_carry", ifo.carryOut, 32'h1);
    check("one_ctl", ifo.controlOut, 32'h0);
    @(negedge clock);
    check("one_carry_end", ifo.carryOut, 32'h0);
    repeat (5) @(negedge clock);
    check("one_ctl_later", ifo.controlOut, 32'h0);

    // Reset asserted mid-count and mid-scan
    ifw.countEnable = 1'b1; ifw.up = 1'b1;
    repeat (3) @(negedge clock);
    check("midrun_count", ifw.digitsOut, 32'h1237);
    #2 reset = 1'b1;
    #1;
    check("midrst_digits", ifw.digitsOut, 32'h0);
    check("midrst_ctl", ifw.controlOut, 32'hE);
    check("midrst_seg", ifw.segOut, 32'hC0);
    check("midrst_carry", ifw.carryOut, 32'h0);
    @(negedge clock);
    idle_all();
    reset = 1'b0;
    @(negedge clock);
    check("midrst_release_digits", ifw.digitsOut, 32'h0);
    check("midrst_release_ctl", ifw.controlOut, 32'hE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
